param_control_unit: RTL and testbench

- Parametrised multicycle control FSM for the CPU datapath; next generation of the 16-bit control unit.
- Decodes the externally latched instruction and drives one-hot register strobes, ALU controls, PC and instruction-register enables, and memory handshake.
- New behaviour:
  - configurable data width and register count
  - variable-latency memory (req/ready)
  - load/store, branch-if-not-zero, halt
  - run gating and illegal-opcode flag

---
 rtl/cu_pkg.sv | 38 +++
 rtl/cu_output_decode.sv | 124 ++++++++++++
 rtl/param_control_unit.sv | 114 +++++++++++
 tb/tb_param_control_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM state
// encoding and instruction field-offset helpers.
package cu_pkg;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_LD   = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_BNZ  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_E1     = 4'd3,
    S_E2     = 4'd4,
    S_E3     = 4'd5,
    S_HALT   = 4'd6
  } state_t;

  // MSB positions of the rx and ry register fields below the 4-bit opcode
  function automatic int rx_msb(int data_w);
    return data_w - 5;
  endfunction

  function automatic int ry_msb(int data_w, int rw);
    return data_w - 5 - rw;
  endfunction

  function automatic logic op_legal(logic [3:0] op);
    return (op <= OP_BNZ) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/cu_output_decode.sv
// Combinational strobe decode: maps the current FSM state and the latched
// instruction onto every datapath, memory and status output.
module cu_output_decode
  import cu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int IMM_W  = 8
) (
  input  state_t              state,
  input  logic [DATA_W-1:0]   instr,
  input  logic                mem_ready,
  output logic [NREG-1:0]     rin,
  output logic [NREG-1:0]     rout,
  output logic                gin,
  output logic                gout,
  output logic                a_in,
  output logic                addsub,
  output logic                xorctrl,
  output logic                ctrl_out,
  output logic [DATA_W-1:0]   imm_out,
  output logic                pcin,
  output logic                pc_enable,
  output logic                instr_enable,
  output logic                addr_in,
  output logic                ram_addr_sel,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ram_out_ctrl,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);

  localparam int RW     = $clog2(NREG);
  localparam int RX_MSB = rx_msb(DATA_W);
  localparam int RY_MSB = ry_msb(DATA_W, RW);
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [3:0]      opcode;
  logic [RW-1:0]   rx;
  logic [RW-1:0]   ry;
  logic [NREG-1:0] rx_oh;
  logic [NREG-1:0] ry_oh;

  assign opcode  = instr[DATA_W-1 -: 4];
  assign rx      = instr[RX_MSB -: RW];
  assign ry      = instr[RY_MSB -: RW];
  assign rx_oh   = ONE << rx;
  assign ry_oh   = ONE << ry;
  assign imm_out = DATA_W'(instr[IMM_W-1:0]);
  assign busy    = (state != S_IDLE) && (state != S_HALT);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    rin          = '0;
    rout         = '0;
    gin          = 1'b0;
    gout         = 1'b0;
    a_in         = 1'b0;
    addsub       = 1'b0;
    xorctrl      = 1'b0;
    ctrl_out     = 1'b0;
    pcin         = 1'b0;
    pc_enable    = 1'b0;
    instr_enable = 1'b0;
    addr_in      = 1'b0;
    ram_addr_sel = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ram_out_ctrl = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req      = 1'b1;
        instr_enable = mem_ready;
        pc_enable    = mem_ready;
      end
      S_DECODE: illegal = !op_legal(opcode);
      S_E1: begin
        case (opcode)
          OP_MV:                  begin rout = ry_oh; rin = rx_oh;     end
          OP_MVI:                 begin ctrl_out = 1'b1; rin = rx_oh;  end
          OP_ADD, OP_SUB, OP_XOR: begin rout = rx_oh; a_in = 1'b1;     end
          OP_LD, OP_ST:           begin rout = ry_oh; addr_in = 1'b1;  end
          OP_BNZ:                 begin rout = rx_oh; pcin = 1'b1;     end
          default: ;
        endcase
      end
      S_E2: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_XOR: begin
            rout    = ry_oh;
            gin     = 1'b1;
            addsub  = (opcode == OP_SUB);
            xorctrl = (opcode == OP_XOR);
          end
          OP_LD: begin
            mem_req      = 1'b1;
            ram_addr_sel = 1'b1;
          end
          OP_ST: begin
            rout         = rx_oh;
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            ram_addr_sel = 1'b1;
          end
          default: ;
        endcase
      end
      S_E3: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_XOR: begin gout = 1'b1; rin = rx_oh;         end
          OP_LD:                  begin ram_out_ctrl = 1'b1; rin = rx_oh; end
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/param_control_unit.sv
// Parametrised multicycle control FSM: owns the state register and
// next-state logic; all strobes come from cu_output_decode.
module param_control_unit
  import cu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int IMM_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [DATA_W-1:0]   instr,
  input  logic                mem_ready,
  input  logic                g_zero,
  output logic [NREG-1:0]     rin,
  output logic [NREG-1:0]     rout,
  output logic                gin,
  output logic                gout,
  output logic                a_in,
  output logic                addsub,
  output logic                xorctrl,
  output logic                ctrl_out,
  output logic [DATA_W-1:0]   imm_out,
  output logic                pcin,
  output logic                pc_enable,
  output logic                instr_enable,
  output logic                addr_in,
  output logic                ram_addr_sel,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ram_out_ctrl,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);

  state_t     state;
  state_t     state_nx;
  state_t     end_st;
  logic [3:0] opcode;

  assign opcode = instr[DATA_W-1 -: 4];
  // Instructions always complete; run only gates the next fetch
  assign end_st = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (run) state_nx = S_FETCH;
      S_FETCH: if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        if (!op_legal(opcode))                 state_nx = end_st;
        else if (opcode == OP_HALT)            state_nx = S_HALT;
        else if ((opcode == OP_BNZ) && g_zero) state_nx = end_st;
        else                                   state_nx = S_E1;
      end
      S_E1: begin
        case (opcode)
          OP_MV, OP_MVI, OP_BNZ: state_nx = end_st;
          default:               state_nx = S_E2;
        endcase
      end
      S_E2: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_XOR: state_nx = S_E3;
          OP_LD:   if (mem_ready) state_nx = S_E3;
          OP_ST:   if (mem_ready) state_nx = end_st;
          default: state_nx = end_st;
        endcase
      end
      S_E3:    state_nx = end_st;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  cu_output_decode #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .IMM_W  (IMM_W)
  ) u_decode (
    .state        (state),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .rin          (rin),
    .rout         (rout),
    .gin          (gin),
    .gout         (gout),
    .a_in         (a_in),
    .addsub       (addsub),
    .xorctrl      (xorctrl),
    .ctrl_out     (ctrl_out),
    .imm_out      (imm_out),
    .pcin         (pcin),
    .pc_enable    (pc_enable),
    .instr_enable (instr_enable),
    .addr_in      (addr_in),
    .ram_addr_sel (ram_addr_sel),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ram_out_ctrl (ram_out_ctrl),
    .busy         (busy),
    .halted       (halted),
    .illegal      (illegal)
  );

endmodule

// File: tb/tb_param_control_unit.sv
// Scoreboard bench for param_control_unit: a per-instruction cycle model fills
// an expectation queue; a negedge monitor compares every busy cycle.
module tb_param_control_unit;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int IMM_W  = 8;
  localparam int RW     = 3;

  localparam int MV = 0, MVI = 1, ADD = 2, SUB = 3, XOR = 4, LD = 5, ST = 6, BNZ = 7, HALT = 15;

  logic              clk = 1'b0;
  logic              rst, run, mem_ready, g_zero;
  logic [DATA_W-1:0] instr;
  logic [NREG-1:0]   rin, rout;
  logic              gin, gout, a_in, addsub, xorctrl, ctrl_out, pcin, pc_enable;
  logic              instr_enable, addr_in, ram_addr_sel, mem_req, mem_we, ram_out_ctrl;
  logic              busy, halted, illegal;
  logic [DATA_W-1:0] imm_out;

  param_control_unit #(.DATA_W(DATA_W), .NREG(NREG), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .mem_ready(mem_ready), .g_zero(g_zero),
    .rin(rin), .rout(rout), .gin(gin), .gout(gout), .a_in(a_in), .addsub(addsub),
    .xorctrl(xorctrl), .ctrl_out(ctrl_out), .imm_out(imm_out), .pcin(pcin),
    .pc_enable(pc_enable), .instr_enable(instr_enable), .addr_in(addr_in),
    .ram_addr_sel(ram_addr_sel), .mem_req(mem_req), .mem_we(mem_we),
    .ram_out_ctrl(ram_out_ctrl), .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREG-1:0] rin;
    logic [NREG-1:0] rout;
    logic gin, gout, a_in, addsub, xorctrl, ctrl_out, pcin, pc_enable;
    logic instr_enable, addr_in, ram_addr_sel, mem_req, mem_we, ram_out_ctrl, illegal, halted;
  } out_t;

  typedef struct {
    out_t              o;
    logic [DATA_W-1:0] imm;
  } exp_t;

  typedef struct {
    logic [DATA_W-1:0] word;
    logic              gz;
  } ins_t;

  exp_t exp_q[$];
  ins_t prog_q[$];
  int   mem_lat_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;
  logic ie_seen  = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic out_t actual();
    out_t a;
    a.rin = rin; a.rout = rout; a.gin = gin; a.gout = gout; a.a_in = a_in;
    a.addsub = addsub; a.xorctrl = xorctrl; a.ctrl_out = ctrl_out; a.pcin = pcin;
    a.pc_enable = pc_enable; a.instr_enable = instr_enable; a.addr_in = addr_in;
    a.ram_addr_sel = ram_addr_sel; a.mem_req = mem_req; a.mem_we = mem_we;
    a.ram_out_ctrl = ram_out_ctrl; a.illegal = illegal; a.halted = halted;
    return a;
  endfunction

  task automatic push_exp(input out_t o, input logic [DATA_W-1:0] imm);
    exp_t e;
    e.o = o; e.imm = imm;
    exp_q.push_back(e);
  endtask

  // Reference model: expected output on every cycle of one instruction,
  // fetch through last execute step, given its memory wait counts.
  task automatic add_instr(input int op, input int rx, input int ry, input int imm,
                           input logic gz, input int flat, input int mlat);
    ins_t              ins;
    out_t              o;
    logic [DATA_W-1:0] w, immx;
    logic [NREG-1:0]   ohx, ohy;
    w = DATA_W'(op) << (DATA_W - 4);
    w |= DATA_W'(rx) << (DATA_W - 4 - RW);
    if (op == MVI) w |= DATA_W'(imm);
    else           w |= DATA_W'(ry) << (DATA_W - 4 - 2 * RW);
    immx = DATA_W'(w[IMM_W-1:0]);
    ohx = '0; ohx[rx] = 1'b1;
    ohy = '0; ohy[ry] = 1'b1;
    ins.word = w; ins.gz = gz;
    prog_q.push_back(ins);
    mem_lat_q.push_back(flat);
    if (op == LD || op == ST) mem_lat_q.push_back(mlat);

    for (int i = 0; i < flat; i++) begin o = '0; o.mem_req = 1'b1; push_exp(o, immx); end
    o = '0; o.mem_req = 1'b1; o.instr_enable = 1'b1; o.pc_enable = 1'b1; push_exp(o, immx);
    o = '0; o.illegal = !((op <= BNZ) || (op == HALT)); push_exp(o, immx);
    case (op)
      MV:  begin o = '0; o.rout = ohy; o.rin = ohx; push_exp(o, immx); end
      MVI: begin o = '0; o.ctrl_out = 1'b1; o.rin = ohx; push_exp(o, immx); end
      ADD, SUB, XOR: begin
        o = '0; o.rout = ohx; o.a_in = 1'b1; push_exp(o, immx);
        o = '0; o.rout = ohy; o.gin = 1'b1; o.addsub = (op == SUB); o.xorctrl = (op == XOR);
        push_exp(o, immx);
        o = '0; o.gout = 1'b1; o.rin = ohx; push_exp(o, immx);
      end
      LD: begin
        o = '0; o.rout = ohy; o.addr_in = 1'b1; push_exp(o, immx);
        for (int i = 0; i <= mlat; i++) begin
          o = '0; o.mem_req = 1'b1; o.ram_addr_sel = 1'b1; push_exp(o, immx);
        end
        o = '0; o.ram_out_ctrl = 1'b1; o.rin = ohx; push_exp(o, immx);
      end
      ST: begin
        o = '0; o.rout = ohy; o.addr_in = 1'b1; push_exp(o, immx);
        for (int i = 0; i <= mlat; i++) begin
          o = '0; o.rout = ohx; o.mem_req = 1'b1; o.mem_we = 1'b1; o.ram_addr_sel = 1'b1;
          push_exp(o, immx);
        end
      end
      BNZ: if (!gz) begin o = '0; o.rout = ohx; o.pcin = 1'b1; push_exp(o, immx); end
      default: ;
    endcase
  endtask

  // Instruction register and variable-latency memory emulation
  always @(negedge clk) ie_seen = instr_enable;

  initial begin
    ins_t ins;
    int   lat, cnt;
    logic in_acc;
    in_acc = 1'b0; lat = 0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (ie_seen && prog_q.size() > 0) begin
        ins = prog_q.pop_front();
        instr = ins.word;
        g_zero = ins.gz;
      end
      if (mem_req) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          cnt = 0;
          lat = (mem_lat_q.size() > 0) ? mem_lat_q.pop_front() : 0;
        end
        if (cnt == lat) begin mem_ready = 1'b1; in_acc = 1'b0; end
        else begin mem_ready = 1'b0; cnt++; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: every busy cycle must match the next modelled cycle
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst && busy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_busy", 64'(busy), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("cycle_outputs", 64'(actual()), 64'(e.o));
        if (e.o.ctrl_out) check("imm_out", 64'(imm_out), 64'(e.imm));
      end
    end
  end

  initial begin
    logic ok;
    int   op;
    rst = 1'b0; run = 1'b0; instr = '0; g_zero = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(actual()), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", 64'(actual()), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    add_instr(MVI, 3, 0, 8'h5A, 1'b0, 0, 0);
    add_instr(ADD, 3, 3, 0, 1'b0, 0, 0);
    add_instr(LD, 1, 2, 0, 1'b0, 0, 3);
    add_instr(BNZ, 4, 0, 0, 1'b0, 1, 0);
    add_instr(BNZ, 4, 0, 0, 1'b1, 0, 0);
    add_instr(4'hA, 2, 5, 0, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 8);
      if (op == 8) op = $urandom_range(8, 14);
      add_instr(op, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end
    add_instr(HALT, 0, 0, 0, 1'b0, 1, 0);

    mon_en = 1'b1;
    run = 1'b1;
    @(negedge clk);
    check("fetch_after_run", 64'(mem_req), 64'd1);

    for (int i = 0; i < 5000 && !halted; i++) @(negedge clk);
    check("halt_reached", 64'(halted), 64'd1);
    check("model_drained", 64'(exp_q.size()), 64'd0);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (mem_req || busy || !halted) ok = 1'b0;
    end
    check("halt_holds", 64'(ok), 64'd1);
    mon_en = 1'b0;

    // Leave HALT by reset, then reset again in the middle of a stalled store
    prog_q.push_back('{word: 16'h6B80, gz: 1'b0});
    mem_lat_q.push_back(0);
    mem_lat_q.push_back(40);
    rst = 1'b0;
    #1 check("rst_clears_halt", 64'({halted, busy}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("post_rst_idle", 64'(busy), 64'd0);
    for (int i = 0; i < 60 && !mem_we; i++) @(negedge clk);
    check("st_reached", 64'(mem_we), 64'd1);
    @(negedge clk);
    check("st_req_held", 64'({mem_req, mem_we, ram_addr_sel, rout}), 64'({3'b111, 8'b0010_0000}));
    rst = 1'b0;
    #1 check("rst_drops_req", 64'({mem_req, mem_we, busy}), 64'd0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_rst", 64'({busy, actual()}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
